// File: rtl/riscv_pkg.sv
// Core-wide RV32 constants and types shared by the datapath blocks.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file.sv
// RV32 integer register file: two combinational read ports and one synchronous write port.
// x0 reads as zero; a rising edge on done prints every register once (simulation only).
module register_file #(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned NREGS = riscv_pkg::NREGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we3,
  input  riscv_pkg::reg_addr_t a1,
  input  riscv_pkg::reg_addr_t a2,
  input  riscv_pkg::reg_addr_t a3,
  input  logic [XLEN-1:0]      wd3,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2,
  input  logic                 done
);
  import riscv_pkg::*;

  // x0 has no storage; entries 1..NREGS-1 are flops.
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we3 && (a3 != ZERO_REG)) begin
      for (int i = 1; i < NREGS; i++) begin
        if (a3 == reg_addr_t'(i)) begin
          r_regs[i] <= wd3;
        end
      end
    end
  end

  // No write-to-read bypass: reads see the pre-edge contents.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (a1 == reg_addr_t'(i)) begin
        w_rd1 = r_regs[i];
      end
      if (a2 == reg_addr_t'(i)) begin
        w_rd2 = r_regs[i];
      end
    end
  end

  assign rd1 = w_rd1;
  assign rd2 = w_rd2;

`ifndef SYNTHESIS
  logic        r_done_q;
  int unsigned r_dump_cnt = 0;

  task automatic dump_regs();
    $display("register_file: register dump at %0t", $time);
    $display("x0 = 0x%08h", {XLEN{1'b0}});
    for (int i = 1; i < NREGS; i++) begin
      $display("x%0d = 0x%08h", i, r_regs[i]);
    end
  endtask

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= done;
      if (done && !r_done_q) begin
        dump_regs();
        r_dump_cnt <= r_dump_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(we3)) else $error("register_file: we3 is unknown while out of reset");
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we3;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  register_file dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we3  (we3),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .wd3  (wd3),
    .rd1  (rd1),
    .rd2  (rd2),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample just after the rising edge.
  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we3   = 1'b1;
    a3    = 5'd5;
    wd3   = 32'hFFFF_FFFF;
    a1    = 5'd5;
    a2    = 5'd0;
    done  = 1'b0;

    // Writes during reset are ignored.
    edge_settle();
    edge_settle();
    chk("rst_rd1_in_reset", rd1, 32'h0);
    chk("rst_rd2_in_reset", rd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we3   = 1'b0;
    #1;
    chk("rst_rd1_x5_after_release", rd1, 32'h0);

    // Write x1, no bypass before the edge.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd1; wd3 = 32'h1234_5678; a1 = 5'd1;
    #1;
    chk("x1_before_edge", rd1, 32'h0);
    edge_settle();
    chk("x1_after_edge", rd1, 32'h1234_5678);
    @(negedge clk);
    we3 = 1'b0;

    // Write x2, read on port 2.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd2; wd3 = 32'h8765_4321; a2 = 5'd2;
    #1;
    chk("x2_before_edge", rd2, 32'h0);
    edge_settle();
    chk("x2_rd2", rd2, 32'h8765_4321);
    chk("x1_rd1_held", rd1, 32'h1234_5678);

    // x0 protection.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hDEAD_BEEF;
    edge_settle();
    a1 = 5'd0; a2 = 5'd1;
    #1;
    chk("x0_rd1", rd1, 32'h0);
    chk("x0_no_disturb_rd2", rd2, 32'h1234_5678);

    // Write enable low.
    @(negedge clk);
    we3 = 1'b0; a3 = 5'd3; wd3 = 32'hCAFE_F00D;
    edge_settle();
    a1 = 5'd3;
    #1;
    chk("we_low_x3", rd1, 32'h0);

    // Fill x1..x31 and read back on both ports.
    for (int n = 1; n < 32; n++) begin
      @(negedge clk);
      we3 = 1'b1; a3 = 5'(n); wd3 = 32'h1000_0000 + n;
    end
    @(negedge clk);
    we3 = 1'b0;
    for (int n = 0; n < 32; n++) begin
      a1 = 5'(n);
      a2 = 5'(31 - n);
      #1;
      chk($sformatf("fill_rd1_x%0d", n), rd1, (n == 0) ? 32'h0 : 32'h1000_0000 + n);
      chk($sformatf("fill_rd2_x%0d", 31 - n), rd2,
          (n == 31) ? 32'h0 : 32'h1000_0000 + (31 - n));
    end

    // Dump: done high two cycles, then held, then re-raised.
    @(negedge clk);
    done = 1'b1;
    edge_settle();
    edge_settle();
    chk("dump_first", dut.r_dump_cnt, 32'd1);
    edge_settle();
    chk("dump_held_no_repeat", dut.r_dump_cnt, 32'd1);
    a1 = 5'd5; a2 = 5'd31;
    #1;
    chk("dump_no_effect_rd1", rd1, 32'h1000_0005);
    chk("dump_no_effect_rd2", rd2, 32'h1000_001F);
    @(negedge clk);
    done = 1'b0;
    edge_settle();
    chk("dump_after_drop", dut.r_dump_cnt, 32'd1);
    @(negedge clk);
    done = 1'b1;
    edge_settle();
    chk("dump_second", dut.r_dump_cnt, 32'd2);
    @(negedge clk);
    done = 1'b0;

    // Mid-run async reset clears immediately.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hA5A5_A5A5; a1 = 5'd7;
    edge_settle();
    chk("x7_written", rd1, 32'hA5A5_A5A5);
    @(negedge clk);
    we3 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_x7_immediate", rd1, 32'h0);
    chk("midrst_x31_immediate", rd2, 32'h0);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h5A5A_5A5A;
    edge_settle();
    chk("midrst_write_ignored", rd1, 32'h0);
    @(negedge clk);
    we3 = 1'b0;
    rst_n = 1'b1;
    edge_settle();
    chk("post_rst_x7", rd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
